seq_rca_alu: RTL

Parametrised, multi-cycle successor to the 4-bit combinational ripple-carry adder. Adds, subtracts or accumulates WIDTH-bit operands by iterating one SLICE-bit ripple-carry stage per clock, carrying between slices in a flop. It has a start/busy/done handshake and an internal accumulator. It sits behind the board switch/push-button front end, where it drives result LEDs, and is reused as a small datapath ALU.

---
 rtl/seq_rca_alu.sv | 149 ++++++++++++++
 1 files changed

// File: rtl/seq_rca_alu.sv
// Multi-cycle ripple-carry ALU: adds one SLICE-bit chunk per clock, LSB first,
// with a start/busy/done handshake and a result register that doubles as accumulator.
module seq_rca_alu #(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned SLICE = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] S,
    output logic             Cout,
    output logic             Ovfl
);

    localparam int unsigned NSLICE = WIDTH / SLICE;
    localparam int unsigned CNT_W  = (NSLICE > 1) ? $clog2(NSLICE) : 1;

    localparam logic [1:0] OP_ADD = 2'b00;
    localparam logic [1:0] OP_SUB = 2'b01;
    localparam logic [1:0] OP_ACC = 2'b10;
    localparam logic [1:0] OP_CLR = 2'b11;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        CALC = 2'b01,
        DONE = 2'b10
    } state_e;

    state_e             state_q, state_d;
    logic [WIDTH-1:0]   opa_q, opa_d;
    logic [WIDTH-1:0]   opb_q, opb_d;
    logic [WIDTH-1:0]   psum_q, psum_d;
    logic [WIDTH-1:0]   s_q, s_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               carry_q, carry_d;
    logic               cout_q, cout_d;
    logic               ovfl_q, ovfl_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;

    // Current slice adder; operands shift right so the active slice is always at the bottom
    logic [SLICE:0]     slice_sum_c;
    logic               msb_cin_c;
    logic [WIDTH-1:0]   psum_next_c;
    logic               last_slice_c;

    assign slice_sum_c  = (SLICE+1)'(opa_q[SLICE-1:0]) + (SLICE+1)'(opb_q[SLICE-1:0])
                        + (SLICE+1)'(carry_q);
    assign msb_cin_c    = opa_q[SLICE-1] ^ opb_q[SLICE-1] ^ slice_sum_c[SLICE-1];
    assign psum_next_c  = (psum_q >> SLICE)
                        | (WIDTH'(slice_sum_c[SLICE-1:0]) << (WIDTH - SLICE));
    assign last_slice_c = (cnt_q == CNT_W'(NSLICE - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            opa_q   <= '0;
            opb_q   <= '0;
            psum_q  <= '0;
            s_q     <= '0;
            cnt_q   <= '0;
            carry_q <= 1'b0;
            cout_q  <= 1'b0;
            ovfl_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            opa_q   <= opa_d;
            opb_q   <= opb_d;
            psum_q  <= psum_d;
            s_q     <= s_d;
            cnt_q   <= cnt_d;
            carry_q <= carry_d;
            cout_q  <= cout_d;
            ovfl_q  <= ovfl_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    always_comb begin
        state_d = state_q;
        opa_d   = opa_q;
        opb_d   = opb_q;
        psum_d  = psum_q;
        s_d     = s_q;
        cnt_d   = cnt_q;
        carry_d = carry_q;
        cout_d  = cout_q;
        ovfl_d  = ovfl_q;
        busy_d  = 1'b0;
        done_d  = 1'b0;

        unique case (state_q)
            IDLE, DONE: begin
                state_d = IDLE;
                if (start) begin
                    if (op == OP_CLR) begin
                        state_d = DONE;
                        done_d  = 1'b1;
                        s_d     = '0;
                        cout_d  = 1'b0;
                        ovfl_d  = 1'b0;
                    end else begin
                        state_d = CALC;
                        busy_d  = 1'b1;
                        opa_d   = (op == OP_ACC) ? s_q : A;
                        opb_d   = (op == OP_SUB) ? ~B : B;
                        carry_d = (op == OP_SUB) ? 1'b1 : cin;
                        cnt_d   = '0;
                        psum_d  = '0;
                    end
                end
            end
            CALC: begin
                opa_d   = opa_q >> SLICE;
                opb_d   = opb_q >> SLICE;
                carry_d = slice_sum_c[SLICE];
                psum_d  = psum_next_c;
                cnt_d   = cnt_q + CNT_W'(1);
                if (last_slice_c) begin
                    // Final slice: publish the full result and flags in one edge
                    state_d = DONE;
                    done_d  = 1'b1;
                    s_d     = psum_next_c;
                    cout_d  = slice_sum_c[SLICE];
                    ovfl_d  = msb_cin_c ^ slice_sum_c[SLICE];
                end else begin
                    busy_d  = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign busy = busy_q;
    assign done = done_q;
    assign S    = s_q;
    assign Cout = cout_q;
    assign Ovfl = ovfl_q;

endmodule
